// File: rtl/mxu_sequencer.sv
// Tile sequencer for the systolic MXU: reads config and tile count over the CSR port,
// then runs LOAD/COMPUTE/DRAIN per tile with FIFO back-pressure.
// state     | meaning
// IDLE      | waiting for cs_start with glb_enable
// CFG_RD    | CSR read of the config word issued
// CFG_LAT   | config captured, tile-count read issued
// TILES_LAT | tile count captured, precision checked, cs_ready pulse
// LOAD      | pop COLUMNS input beats (input FIFO plus weight memory)
// COMPUTE   | MXU enabled for MAX_CYC cycles
// DRAIN     | push D output beats, then next tile or DONE
// DONE      | cs_done pulse
`ifndef LOG_ALLOWED_PRECISIONS
`define LOG_ALLOWED_PRECISIONS 3
`endif
`ifndef NO_COMPUTATION
`define NO_COMPUTATION 3'd0
`endif
`ifndef INT8
`define INT8 3'd1
`endif
`ifndef INT16
`define INT16 3'd2
`endif
`ifndef INT32
`define INT32 3'd3
`endif
`ifndef INT64
`define INT64 3'd4
`endif
`ifndef NO_CHAIN
`define NO_CHAIN 1'b0
`endif

module mxu_sequencer #(
  parameter int ROWS                = 3,
  parameter int COLUMNS             = 3,
  parameter int DATA_WIDTH_FIFO_OUT = 64,
  parameter int DATA_WIDTH_CSR      = 8,
  parameter int ADDRESS_SIZE_CSR    = 32,
  parameter int TILE_W              = 8,
  parameter logic [ADDRESS_SIZE_CSR-1:0] A_CFG   = '0,
  parameter logic [ADDRESS_SIZE_CSR-1:0] A_TILES = ADDRESS_SIZE_CSR'(1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                glb_enable,
  input  logic                                cs_start,
  output logic                                cs_idle,
  output logic                                cs_ready,
  output logic                                cs_done,
  output logic                                csr_ce,
  output logic [ADDRESS_SIZE_CSR-1:0]         csr_address,
  input  logic [DATA_WIDTH_CSR-1:0]           csr_dout,
  output logic                                infifo_read,
  input  logic                                infifo_is_empty,
  output logic                                wm_ce,
  output logic                                outfifo_write,
  input  logic                                outfifo_is_full,
  output logic                                enable_mxu,
  output logic [`LOG_ALLOWED_PRECISIONS-1:0]  data_precision,
  output logic                                enable_chain,
  output logic [1:0]                          enable_fp_unit,
  output logic [TILE_W-1:0]                   tile_idx,
  output logic                                stall,
  output logic                                error,
  output logic [3:0]                          state_out
);

  localparam int LOG     = `LOG_ALLOWED_PRECISIONS;
  localparam int MAX_CYC = 3 * (COLUMNS + 1) + 2 * ROWS;
  localparam int D8      = (COLUMNS * 8  + DATA_WIDTH_FIFO_OUT - 1) / DATA_WIDTH_FIFO_OUT;
  localparam int D16     = (COLUMNS * 16 + DATA_WIDTH_FIFO_OUT - 1) / DATA_WIDTH_FIFO_OUT;
  localparam int D32     = (COLUMNS * 32 + DATA_WIDTH_FIFO_OUT - 1) / DATA_WIDTH_FIFO_OUT;
  localparam int D64     = (COLUMNS * 64 + DATA_WIDTH_FIFO_OUT - 1) / DATA_WIDTH_FIFO_OUT;
  localparam int CNT_MAX = (MAX_CYC > D64) ? MAX_CYC : D64;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CFG_RD    = 4'd1,
    CFG_LAT   = 4'd2,
    TILES_LAT = 4'd3,
    LOAD      = 4'd4,
    COMPUTE   = 4'd5,
    DRAIN     = 4'd6,
    DONE      = 4'd7
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [CNT_W-1:0]             r_cnt;
  logic [TILE_W-1:0]            r_n_tiles;
  logic [TILE_W-1:0]            r_tile_idx;
  logic [LOG-1:0]               r_prec;
  logic                         r_chain;
  logic [1:0]                   r_fp;
  logic                         r_err;
  logic                         r_csr_ce;
  logic [ADDRESS_SIZE_CSR-1:0]  r_csr_addr;
  logic                         r_cs_idle;
  logic                         r_cs_ready;
  logic                         r_cs_done;
  logic                         r_infifo_read;
  logic                         r_wm_ce;
  logic                         r_outfifo_write;
  logic                         r_enable_mxu;
  logic                         r_stall;

  logic                         w_prec_ok;
  logic                         w_abort;
  logic                         w_more;
  logic [TILE_W-1:0]            w_tiles_in;
  logic [TILE_W:0]              w_tile_nxt;
  logic [CNT_W-1:0]             w_d_last;

  assign w_tiles_in = csr_dout[TILE_W-1:0];
  assign w_prec_ok  = (r_prec == `INT8) || (r_prec == `INT16) ||
                      (r_prec == `INT32) || (r_prec == `INT64);
  assign w_abort    = (r_state != IDLE) && !glb_enable;
  assign w_tile_nxt = {1'b0, r_tile_idx} + (TILE_W+1)'(1);
  assign w_more     = w_tile_nxt < {1'b0, r_n_tiles};

  always_comb begin
    w_d_last = '0;
    case (r_prec)
      `INT8:   w_d_last = CNT_W'(D8 - 1);
      `INT16:  w_d_last = CNT_W'(D16 - 1);
      `INT32:  w_d_last = CNT_W'(D32 - 1);
      `INT64:  w_d_last = CNT_W'(D64 - 1);
      default: w_d_last = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (cs_start && glb_enable) w_state_nxt = CFG_RD;
      CFG_RD:    w_state_nxt = CFG_LAT;
      CFG_LAT:   w_state_nxt = TILES_LAT;
      TILES_LAT: w_state_nxt = ((w_tiles_in == '0) || !w_prec_ok) ? DONE : LOAD;
      LOAD:      if (!infifo_is_empty && (r_cnt == '0)) w_state_nxt = COMPUTE;
      COMPUTE:   if (r_cnt == '0) w_state_nxt = DRAIN;
      DRAIN:     if (!outfifo_is_full && (r_cnt == '0)) w_state_nxt = w_more ? LOAD : DONE;
      DONE:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
    if (w_abort) w_state_nxt = IDLE;
  end

  // Strobes are registered from the next state so they line up with the state they belong to;
  // this keeps the one-cycle CSR read latency inside CFG_RD/CFG_LAT/TILES_LAT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_n_tiles       <= '0;
      r_tile_idx      <= '0;
      r_prec          <= `NO_COMPUTATION;
      r_chain         <= `NO_CHAIN;
      r_fp            <= '0;
      r_err           <= 1'b0;
      r_csr_ce        <= 1'b0;
      r_csr_addr      <= '0;
      r_cs_idle       <= 1'b0;
      r_cs_ready      <= 1'b0;
      r_cs_done       <= 1'b0;
      r_infifo_read   <= 1'b0;
      r_wm_ce         <= 1'b0;
      r_outfifo_write <= 1'b0;
      r_enable_mxu    <= 1'b0;
      r_stall         <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_csr_ce        <= (w_state_nxt == CFG_RD) || (w_state_nxt == CFG_LAT);
      r_csr_addr      <= (w_state_nxt == CFG_LAT) ? A_TILES :
                         (w_state_nxt == CFG_RD)  ? A_CFG   : '0;
      r_cs_idle       <= (w_state_nxt == IDLE);
      r_cs_ready      <= (w_state_nxt == TILES_LAT);
      r_cs_done       <= (w_state_nxt == DONE);
      r_infifo_read   <= (w_state_nxt == LOAD);
      r_wm_ce         <= (w_state_nxt == LOAD);
      r_enable_mxu    <= (w_state_nxt == COMPUTE);
      r_outfifo_write <= (w_state_nxt == DRAIN);
      r_stall         <= ((r_state == LOAD)  && (w_state_nxt == LOAD)  && infifo_is_empty) ||
                         ((r_state == DRAIN) && (w_state_nxt == DRAIN) && outfifo_is_full);
      if (w_abort) begin
        r_cnt      <= '0;
        r_tile_idx <= '0;
      end else begin
        case (r_state)
          IDLE: if (cs_start && glb_enable) r_err <= 1'b0;
          CFG_LAT: begin
            r_prec  <= csr_dout[LOG-1:0];
            r_chain <= csr_dout[LOG];
            r_fp    <= csr_dout[LOG+2:LOG+1];
          end
          TILES_LAT: begin
            r_n_tiles  <= w_tiles_in;
            r_tile_idx <= '0;
            r_cnt      <= CNT_W'(COLUMNS - 1);
            if (!w_prec_ok) r_err <= 1'b1;
          end
          LOAD: if (!infifo_is_empty)
            r_cnt <= (r_cnt == '0) ? CNT_W'(MAX_CYC - 1) : r_cnt - CNT_W'(1);
          COMPUTE: r_cnt <= (r_cnt == '0) ? w_d_last : r_cnt - CNT_W'(1);
          DRAIN: if (!outfifo_is_full) begin
            if (r_cnt == '0) begin
              r_tile_idx <= w_tile_nxt[TILE_W-1:0];
              r_cnt      <= CNT_W'(COLUMNS - 1);
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  assign cs_idle        = r_cs_idle;
  assign cs_ready       = r_cs_ready;
  assign cs_done        = r_cs_done;
  assign csr_ce         = r_csr_ce;
  assign csr_address    = r_csr_addr;
  assign infifo_read    = r_infifo_read;
  assign wm_ce          = r_wm_ce;
  assign outfifo_write  = r_outfifo_write;
  assign enable_mxu     = r_enable_mxu;
  assign data_precision = r_prec;
  assign enable_chain   = r_chain;
  assign enable_fp_unit = r_fp;
  assign tile_idx       = r_tile_idx;
  assign stall          = r_stall;
  assign error          = r_err;
  assign state_out      = r_state;

endmodule

// File: tb/tb_mxu_sequencer.sv
// Directed bench for mxu_sequencer: CSR responder, FIFO flag stimulus and a negedge activity monitor.
`ifndef LOG_ALLOWED_PRECISIONS
`define LOG_ALLOWED_PRECISIONS 3
`endif
`ifndef NO_COMPUTATION
`define NO_COMPUTATION 3'd0
`endif
`ifndef INT8
`define INT8 3'd1
`endif
`ifndef INT16
`define INT16 3'd2
`endif
`ifndef INT32
`define INT32 3'd3
`endif
`ifndef INT64
`define INT64 3'd4
`endif
`ifndef NO_CHAIN
`define NO_CHAIN 1'b0
`endif

module tb_mxu_sequencer;
  localparam logic [3:0] S_IDLE = 4'd0, S_LOAD = 4'd4, S_COMPUTE = 4'd5, S_DRAIN = 4'd6;

  logic        clk = 1'b0, reset = 1'b0, glb_enable = 1'b0, cs_start = 1'b0;
  logic        infifo_is_empty = 1'b0, outfifo_is_full = 1'b0;
  logic [7:0]  csr_dout = 8'h00;
  logic        cs_idle, cs_ready, cs_done, csr_ce, infifo_read, wm_ce, outfifo_write, enable_mxu;
  logic [31:0] csr_address;
  logic [2:0]  data_precision;
  logic        enable_chain, stall, error;
  logic [1:0]  enable_fp_unit;
  logic [7:0]  tile_idx;
  logic [3:0]  state_out;

  logic [7:0]  tb_cfg = 8'h00, tb_tiles = 8'h00;
  int errors = 0, checks = 0;
  int mon_cyc, n_ready, ready_cyc, n_done, done_cyc, n_load, n_rd, n_rd_hi, n_wm;
  int n_stall, n_mxu, n_wr, n_wr_hi, n_csr, n_bad;
  int tile_log[$];
  logic       mon_on = 1'b0;
  logic [3:0] prev_state = 4'd0;
  bit ok;

  mxu_sequencer dut (
    .clk(clk), .reset(reset), .glb_enable(glb_enable), .cs_start(cs_start),
    .cs_idle(cs_idle), .cs_ready(cs_ready), .cs_done(cs_done),
    .csr_ce(csr_ce), .csr_address(csr_address), .csr_dout(csr_dout),
    .infifo_read(infifo_read), .infifo_is_empty(infifo_is_empty), .wm_ce(wm_ce),
    .outfifo_write(outfifo_write), .outfifo_is_full(outfifo_is_full),
    .enable_mxu(enable_mxu), .data_precision(data_precision), .enable_chain(enable_chain),
    .enable_fp_unit(enable_fp_unit), .tile_idx(tile_idx), .stall(stall), .error(error),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (csr_ce) csr_dout <= (csr_address == 32'd0) ? tb_cfg : (csr_address == 32'd1) ? tb_tiles : 8'h00;

  always @(negedge clk) if (mon_on) begin
    if (cs_ready) begin n_ready++; ready_cyc = mon_cyc; end
    if (cs_done) begin n_done++; done_cyc = mon_cyc; end
    if (state_out == S_LOAD) n_load++;
    if (state_out == S_LOAD && prev_state != S_LOAD) tile_log.push_back(int'(tile_idx));
    if (infifo_read) n_rd_hi++;
    if (infifo_read && !infifo_is_empty) n_rd++;
    if (wm_ce && !infifo_is_empty) n_wm++;
    if (stall) n_stall++;
    if (enable_mxu) n_mxu++;
    if (outfifo_write) n_wr_hi++;
    if (outfifo_write && !outfifo_is_full) n_wr++;
    if (csr_ce) n_csr++;
    if (stall && enable_mxu) n_bad++;
    prev_state = state_out;
    mon_cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    mon_cyc = 0; n_ready = 0; ready_cyc = -1; n_done = 0; done_cyc = -1; n_load = 0;
    n_rd = 0; n_rd_hi = 0; n_wm = 0; n_stall = 0; n_mxu = 0; n_wr = 0; n_wr_hi = 0;
    n_csr = 0; n_bad = 0; prev_state = S_IDLE; tile_log.delete();
  endtask

  // Cycle 0 is the cycle in which cs_start is first seen by the DUT.
  task automatic start_run(input logic [7:0] cfg, input logic [7:0] tiles);
    @(posedge clk); #1;
    tb_cfg = cfg; tb_tiles = tiles;
    clear_mon();
    mon_on = 1'b1;
    cs_start = 1'b1;
    @(posedge clk); #1;
    cs_start = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (state_out == s) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (cs_done) begin got = 1'b1; break; end
    end
    repeat (2) @(posedge clk);
    #1 mon_on = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({csr_ce, infifo_read, wm_ce, outfifo_write, enable_mxu, cs_idle, cs_ready, cs_done, stall, error} !== 10'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0", {csr_ce, infifo_read, wm_ce, outfifo_write, enable_mxu, cs_idle, cs_ready, cs_done, stall, error}); end
    checks++; if (data_precision !== `NO_COMPUTATION) begin errors++; $display("FAIL reset_precision: got %0d expected %0d", data_precision, `NO_COMPUTATION); end
    checks++; if (enable_chain !== `NO_CHAIN) begin errors++; $display("FAIL reset_chain: got %b", enable_chain); end
    checks++; if ({enable_fp_unit, tile_idx, csr_address, state_out} !== 46'd0) begin errors++; $display("FAIL reset_fields: got %h expected 0", {enable_fp_unit, tile_idx, csr_address, state_out}); end
    repeat (2) @(negedge clk);
    reset = 1'b1; glb_enable = 1'b1;
    @(posedge clk); #1;
    checks++; if (cs_idle !== 1'b1) begin errors++; $display("FAIL reset_first_idle: got %b expected 1", cs_idle); end
  endtask

  task automatic test_single_tile();
    start_run(8'h2A, 8'd1);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout: got none expected cs_done"); end
    checks++; if (ready_cyc !== 3 || n_ready !== 1) begin errors++; $display("FAIL single_ready: got cycle %0d count %0d expected cycle 3 count 1", ready_cyc, n_ready); end
    checks++; if (n_load !== 3 || n_rd !== 3 || n_wm !== 3) begin errors++; $display("FAIL single_load: got load %0d rd %0d wm %0d expected 3", n_load, n_rd, n_wm); end
    checks++; if (n_mxu !== 18) begin errors++; $display("FAIL single_mxu_cycles: got %0d expected 18", n_mxu); end
    checks++; if (n_wr !== 1) begin errors++; $display("FAIL single_drain_beats: got %0d expected 1", n_wr); end
    checks++; if (n_done !== 1 || done_cyc !== 26) begin errors++; $display("FAIL single_done: got count %0d cycle %0d expected 1 at 26", n_done, done_cyc); end
    checks++; if (n_csr !== 2) begin errors++; $display("FAIL single_csr_reads: got %0d expected 2", n_csr); end
    checks++; if (data_precision !== `INT16 || enable_chain !== 1'b1 || enable_fp_unit !== 2'd2) begin errors++; $display("FAIL single_cfg: got prec %0d chain %b fp %0d expected 2 1 2", data_precision, enable_chain, enable_fp_unit); end
    checks++; if (error !== 1'b0 || n_stall !== 0) begin errors++; $display("FAIL single_no_err_stall: got err %b stalls %0d expected 0 0", error, n_stall); end
    checks++; if (tile_idx !== 8'd1) begin errors++; $display("FAIL single_tile_idx_end: got %0d expected 1", tile_idx); end
  endtask

  task automatic test_back_to_back();
    start_run(8'h04, 8'd3);
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout: got none expected cs_done"); end
    checks++; if (n_load !== 9 || n_mxu !== 54) begin errors++; $display("FAIL b2b_load_mxu: got load %0d mxu %0d expected 9 54", n_load, n_mxu); end
    checks++; if (n_wr !== 9) begin errors++; $display("FAIL b2b_drain_beats: got %0d expected 9", n_wr); end
    checks++; if (n_done !== 1 || done_cyc !== 76) begin errors++; $display("FAIL b2b_done: got count %0d cycle %0d expected 1 at 76", n_done, done_cyc); end
    checks++; if (n_csr !== 2) begin errors++; $display("FAIL b2b_csr_reads: got %0d expected 2", n_csr); end
    checks++;
    if (tile_log.size() !== 3) begin errors++; $display("FAIL b2b_tile_passes: got %0d expected 3", tile_log.size()); end
    else for (int k = 0; k < 3; k++) begin
      if (tile_log[k] !== k) begin errors++; $display("FAIL b2b_tile_idx: got %0d expected %0d", tile_log[k], k); end
    end
    checks++; if (tile_idx !== 8'd3) begin errors++; $display("FAIL b2b_tile_idx_end: got %0d expected 3", tile_idx); end
  endtask

  task automatic test_infifo_stall();
    start_run(8'h2A, 8'd1);
    wait_state(S_LOAD, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL install_load_timeout: got state %0d expected LOAD", state_out); end
    infifo_is_empty = 1'b1;
    repeat (5) @(posedge clk);
    #1 infifo_is_empty = 1'b0;
    wait_done(200, ok);
    checks++; if (!ok || n_done !== 1) begin errors++; $display("FAIL install_done: got %0d expected 1", n_done); end
    checks++; if (n_stall !== 5) begin errors++; $display("FAIL install_stall_cycles: got %0d expected 5", n_stall); end
    checks++; if (n_rd !== 3 || n_rd_hi !== 8 || n_load !== 8) begin errors++; $display("FAIL install_reads: got beats %0d high %0d load %0d expected 3 8 8", n_rd, n_rd_hi, n_load); end
    checks++; if (n_mxu !== 18 || n_wr !== 1) begin errors++; $display("FAIL install_rest: got mxu %0d wr %0d expected 18 1", n_mxu, n_wr); end
  endtask

  task automatic test_outfifo_full();
    start_run(8'h2A, 8'd1);
    wait_state(S_DRAIN, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL outfull_drain_timeout: got state %0d expected DRAIN", state_out); end
    outfifo_is_full = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (stall !== 1'b1 || enable_mxu !== 1'b0) begin errors++; $display("FAIL outfull_mid: got stall %b mxu %b expected 1 0", stall, enable_mxu); end
    repeat (2) @(posedge clk);
    #1 outfifo_is_full = 1'b0;
    wait_done(100, ok);
    checks++; if (!ok || n_done !== 1) begin errors++; $display("FAIL outfull_done: got %0d expected 1", n_done); end
    checks++; if (n_stall !== 4 || n_bad !== 0) begin errors++; $display("FAIL outfull_stall: got stall %0d overlap %0d expected 4 0", n_stall, n_bad); end
    checks++; if (n_wr !== 1 || n_wr_hi !== 5) begin errors++; $display("FAIL outfull_beats: got beats %0d high %0d expected 1 5", n_wr, n_wr_hi); end
    checks++; if (n_mxu !== 18) begin errors++; $display("FAIL outfull_mxu: got %0d expected 18", n_mxu); end
  endtask

  task automatic test_zero_tiles();
    start_run(8'h2A, 8'd0);
    wait_done(40, ok);
    checks++; if (!ok || ready_cyc !== 3 || done_cyc !== 4) begin errors++; $display("FAIL zero_timing: got ready %0d done %0d expected 3 4", ready_cyc, done_cyc); end
    checks++; if (n_mxu !== 0 || n_load !== 0 || n_wr !== 0 || error !== 1'b0) begin errors++; $display("FAIL zero_activity: got mxu %0d load %0d wr %0d err %b expected 0", n_mxu, n_load, n_wr, error); end
  endtask

  task automatic test_bad_precision();
    start_run(8'h07, 8'd2);
    wait_done(40, ok);
    checks++; if (!ok || done_cyc !== 4 || n_done !== 1) begin errors++; $display("FAIL badprec_done: got cycle %0d count %0d expected 4 1", done_cyc, n_done); end
    checks++; if (error !== 1'b1 || data_precision !== 3'd7) begin errors++; $display("FAIL badprec_error: got err %b prec %0d expected 1 7", error, data_precision); end
    checks++; if (n_mxu !== 0 || n_load !== 0 || n_wr !== 0) begin errors++; $display("FAIL badprec_activity: got mxu %0d load %0d wr %0d expected 0", n_mxu, n_load, n_wr); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL badprec_sticky: got %b expected 1", error); end
    start_run(8'h01, 8'd1);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL badprec_clear_on_start: got %b expected 0", error); end
    wait_done(200, ok);
    checks++; if (!ok || error !== 1'b0 || n_wr !== 1) begin errors++; $display("FAIL int8_run: got err %b wr %0d expected 0 1", error, n_wr); end
  endtask

  task automatic test_abort_and_reset();
    start_run(8'h2A, 8'd1);
    wait_state(S_COMPUTE, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_compute_timeout: got state %0d expected COMPUTE", state_out); end
    repeat (3) @(posedge clk);
    #1 glb_enable = 1'b0;
    @(posedge clk); #1;
    checks++; if (state_out !== S_IDLE || enable_mxu !== 1'b0 || cs_idle !== 1'b1) begin errors++; $display("FAIL abort_idle: got state %0d mxu %b idle %b expected 0 0 1", state_out, enable_mxu, cs_idle); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (n_done !== 0 || state_out !== S_IDLE) begin errors++; $display("FAIL abort_no_done: got done %0d state %0d expected 0 0", n_done, state_out); end
    glb_enable = 1'b1;
    mon_on = 1'b0;
    start_run(8'h2A, 8'd1);
    wait_state(S_LOAD, 20, ok);
    checks++; if (!ok || infifo_read !== 1'b1) begin errors++; $display("FAIL rst_load_reach: got state %0d read %b expected LOAD 1", state_out, infifo_read); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({csr_ce, infifo_read, wm_ce, outfifo_write, enable_mxu, cs_idle, cs_ready, cs_done, stall, error} !== 10'b0 || state_out !== S_IDLE) begin errors++; $display("FAIL rst_async_outputs: got %b state %0d expected 0", {csr_ce, infifo_read, wm_ce, outfifo_write, enable_mxu, cs_idle, cs_ready, cs_done, stall, error}, state_out); end
    checks++; if (data_precision !== `NO_COMPUTATION || enable_chain !== `NO_CHAIN || enable_fp_unit !== 2'd0 || tile_idx !== 8'd0) begin errors++; $display("FAIL rst_async_cfg: got prec %0d chain %b fp %0d tile %0d expected reset values", data_precision, enable_chain, enable_fp_unit, tile_idx); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (cs_idle !== 1'b1) begin errors++; $display("FAIL rst_release_idle: got %b expected 1", cs_idle); end
    mon_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_back_to_back();
    test_infifo_stall();
    test_outfifo_full();
    test_zero_tiles();
    test_bad_precision();
    test_abort_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
